// File: rtl/pmod_jstk2_multi.sv
// Round-robin poller for CHANNELS PMOD JSTK2 joysticks sharing one SPI byte engine.
// Define JSTK_HYST_EN to add HYST counts of release hysteresis to the direction bits.
module pmod_jstk2_multi #(
    parameter int         CHANNELS       = 2,
    parameter logic [9:0] MARGIN         = 10'h0C0,
    parameter logic [9:0] HYST           = 10'h040,
    parameter logic [7:0] CMD            = 8'h00,
    parameter int         STARTUP_CYCLES = 262143,
    parameter int         GAP_CYCLES     = 8191,
    parameter int         FRAME_CYCLES   = 65535
) (
    input  logic                   clk_peripheral,
    input  logic                   reset_n,
    output logic [CHANNELS-1:0]    sel,
    output logic [7:0]             dato,
    input  logic [7:0]             dati,
    output logic                   wv,
    input  logic                   wr,
    input  logic                   rv,
    output logic [11*CHANNELS-1:0] joystick,
    output logic [20*CHANNELS-1:0] axes,
    output logic [CHANNELS-1:0]    frame_done
);

    localparam int         CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [9:0] X_HI = 10'd1023 - MARGIN;

    typedef enum logic [3:0] {
        S_START, S_IDLE, S_ENABLE, S_INIT, S_WRITE,
        S_READ, S_STORE, S_WAIT, S_COMMIT, S_FRAME
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [2:0]             bc_q, bc_d;
    logic [CHANNELS-1:0]    sel_q, sel_d;
    logic                   wv_q, wv_d;
    logic [7:0]             dato_q, dato_d;
    logic [7:0]             xl_q, xl_d, yl_q, yl_d;
    logic [1:0]             xh_q, xh_d, yh_q, yh_d, btn_q, btn_d;
    logic [11*CHANNELS-1:0] joy_q, joy_d;
    logic [20*CHANNELS-1:0] axes_q, axes_d;
    logic [CHANNELS-1:0]    fd_q, fd_d;

    logic [9:0]  x_w, y_w;
    logic [10:0] word_w;

    assign x_w = {xh_q, xl_q};
    assign y_w = {yh_q, yl_q};

`ifdef JSTK_HYST_EN
    logic [3:0] prev_w;

    // A set direction bit holds until the axis is HYST counts back inside the margin.
    always_comb begin
        prev_w    = joy_q[int'(ch_q)*11 +: 4];
        word_w    = '0;
        word_w[0] = (x_w > X_HI)   || (prev_w[0] && ({1'b0, x_w} + {1'b0, HYST} > {1'b0, X_HI}));
        word_w[1] = (x_w < MARGIN) || (prev_w[1] && ({1'b0, x_w} < {1'b0, MARGIN} + {1'b0, HYST}));
        word_w[2] = (y_w < MARGIN) || (prev_w[2] && ({1'b0, y_w} < {1'b0, MARGIN} + {1'b0, HYST}));
        word_w[3] = (y_w > X_HI)   || (prev_w[3] && ({1'b0, y_w} + {1'b0, HYST} > {1'b0, X_HI}));
        word_w[5] = btn_q[1];
        word_w[7] = btn_q[0];
    end
`else
    logic unused_hyst;
    assign unused_hyst = ^HYST;

    always_comb begin
        word_w    = '0;
        word_w[0] = x_w > X_HI;
        word_w[1] = x_w < MARGIN;
        word_w[2] = y_w < MARGIN;
        word_w[3] = y_w > X_HI;
        word_w[5] = btn_q[1];
        word_w[7] = btn_q[0];
    end
`endif

    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        bc_d    = bc_q;
        sel_d   = sel_q;
        wv_d    = 1'b0;
        dato_d  = dato_q;
        xl_d    = xl_q;
        xh_d    = xh_q;
        yl_d    = yl_q;
        yh_d    = yh_q;
        btn_d   = btn_q;
        joy_d   = joy_q;
        axes_d  = axes_q;
        fd_d    = '0;
        case (state_q)
            S_START: begin
                cnt_d   = '0;
                ch_d    = '0;
                bc_d    = '0;
                sel_d   = '1;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (cnt_q == 32'(STARTUP_CYCLES)) state_d = S_ENABLE;
                else                              cnt_d   = cnt_q + 32'd1;
            end
            S_ENABLE: begin
                sel_d   = ~(CHANNELS'(1) << ch_q);
                bc_d    = '0;
                state_d = S_INIT;
            end
            S_INIT: begin
                if (wr) begin
                    wv_d    = 1'b1;
                    dato_d  = (bc_q == 3'd0) ? CMD : 8'h00;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_READ;
            S_READ: begin
                if (rv) begin
                    case (bc_q)
                        3'd0:    xl_d  = dati;
                        3'd1:    xh_d  = dati[1:0];
                        3'd2:    yl_d  = dati;
                        3'd3:    yh_d  = dati[1:0];
                        default: btn_d = dati[1:0];
                    endcase
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                bc_d    = bc_q + 3'd1;
                cnt_d   = '0;
                state_d = (bc_q == 3'd4) ? S_COMMIT : S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 32'(GAP_CYCLES)) state_d = S_INIT;
                else                          cnt_d   = cnt_q + 32'd1;
            end
            S_COMMIT: begin
                joy_d[int'(ch_q)*11 +: 11]  = word_w;
                axes_d[int'(ch_q)*20 +: 20] = {y_w, x_w};
                fd_d[ch_q]                  = 1'b1;
                sel_d                       = '1;
                cnt_d                       = '0;
                state_d                     = S_FRAME;
            end
            S_FRAME: begin
                if (cnt_q == 32'(FRAME_CYCLES)) begin
                    ch_d    = (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;
                    state_d = S_ENABLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = S_START;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_peripheral or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_START;
            cnt_q   <= '0;
            ch_q    <= '0;
            bc_q    <= '0;
            sel_q   <= '1;
            wv_q    <= 1'b0;
            dato_q  <= 8'h00;
            xl_q    <= '0;
            xh_q    <= '0;
            yl_q    <= '0;
            yh_q    <= '0;
            btn_q   <= '0;
            joy_q   <= '0;
            axes_q  <= {CHANNELS{20'h80200}};
            fd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            bc_q    <= bc_d;
            sel_q   <= sel_d;
            wv_q    <= wv_d;
            dato_q  <= dato_d;
            xl_q    <= xl_d;
            xh_q    <= xh_d;
            yl_q    <= yl_d;
            yh_q    <= yh_d;
            btn_q   <= btn_d;
            joy_q   <= joy_d;
            axes_q  <= axes_d;
            fd_q    <= fd_d;
        end
    end

    assign sel        = sel_q;
    assign wv         = wv_q;
    assign dato       = dato_q;
    assign joystick   = joy_q;
    assign axes       = axes_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_pmod_jstk2_multi.sv
// Scoreboard bench for pmod_jstk2_multi: a modelled byte engine feeds directed frames,
// a monitor pops the expected words whenever frame_done pulses.
`timescale 1ns/1ps
module tb_pmod_jstk2_multi;

    localparam int         CHANNELS    = 2;
    localparam int         STARTUP     = 40;
    localparam int         GAP         = 3;
    localparam int         FRAME       = 12;
    localparam logic [7:0] CMD_B       = 8'hA5;
    localparam int         HOLD_IDX    = 31;
    localparam int         HOLD_CYCLES = 10000;
`ifdef JSTK_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    typedef struct {
        logic [1:0]  fd;
        logic [21:0] joy;
        logic [39:0] ax;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  sel;
    logic [7:0]  dato;
    logic [7:0]  dati;
    logic        wv;
    logic        wr;
    logic        rv;
    logic [21:0] joystick;
    logic [39:0] axes;
    logic [1:0]  frame_done;

    int n_tests   = 0;
    int n_fail    = 0;
    int served    = 0;
    int sel_viol  = 0;

    exp_t       sb[$];
    logic [7:0] byte_q[$];
    int         ch_exp[$];
    logic [21:0] m_joy;
    logic [39:0] m_axes;

    pmod_jstk2_multi #(
        .CHANNELS(CHANNELS),
        .MARGIN(10'h0C0),
        .HYST(10'h040),
        .CMD(CMD_B),
        .STARTUP_CYCLES(STARTUP),
        .GAP_CYCLES(GAP),
        .FRAME_CYCLES(FRAME)
    ) dut (
        .clk_peripheral(clk),
        .reset_n(reset_n),
        .sel(sel),
        .dato(dato),
        .dati(dati),
        .wv(wv),
        .wr(wr),
        .rv(rv),
        .joystick(joystick),
        .axes(axes),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sel"}, sel, 2'b11);
        check({tag, "_wv"}, wv, 1'b0);
        check({tag, "_joystick"}, joystick, 22'h0);
        check({tag, "_axes"}, axes, {2{20'h80200}});
        check({tag, "_frame_done"}, frame_done, 2'b00);
    endtask

    task automatic push_frame(input int c, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                              input logic [10:0] jw, input logic [19:0] aw);
        exp_t e;
        byte_q.push_back(b0);
        byte_q.push_back(b1);
        byte_q.push_back(b2);
        byte_q.push_back(b3);
        byte_q.push_back(b4);
        ch_exp.push_back(c);
        m_joy[c*11 +: 11]  = jw;
        m_axes[c*20 +: 20] = aw;
        e.fd  = 2'b01 << c;
        e.joy = m_joy;
        e.ax  = m_axes;
        sb.push_back(e);
    endtask

    task automatic wait_first_sel(input string tag);
        int n;
        n = 0;
        while ((&sel) && n < STARTUP + 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_startup_wait"}, 64'((n >= STARTUP) && (n <= STARTUP + 5)), 64'd1);
    endtask

    // Byte engine model: always ready, answers each write with rv four cycles later.
    initial begin : engine
        int         widx;
        int         viol;
        logic [1:0] sel_exp;
        widx = 0;
        forever begin
            @(negedge clk);
            if (&sel) begin
                widx = 0;
            end else if (wv) begin
                check("dato", dato, (widx == 0) ? CMD_B : 8'h00);
                if (byte_q.size() > 0) begin
                    if (widx == 0 && ch_exp.size() > 0) begin
                        sel_exp = ~(2'b01 << ch_exp.pop_front());
                        check("sel_channel", sel, sel_exp);
                    end
                    if (served == HOLD_IDX) begin
                        viol = 0;
                        repeat (HOLD_CYCLES) begin
                            @(negedge clk);
                            if (wv || (&sel) || (|frame_done)) viol++;
                        end
                        check("rv_hold_wait", viol, 0);
                    end else begin
                        repeat (4) @(negedge clk);
                    end
                    dati = byte_q.pop_front();
                    rv   = 1'b1;
                    @(negedge clk);
                    rv   = 1'b0;
                    served++;
                end
                widx++;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if ($countones(~sel) > 1) sel_viol++;
            if (frame_done != 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame_done", frame_done, 2'b00);
                end else begin
                    e = sb.pop_front();
                    check("frame_done", frame_done, e.fd);
                    check("joystick", joystick, e.joy);
                    check("axes", axes, e.ax);
                end
            end
        end
    end

    initial begin : main
        int n;
        reset_n = 1'b0;
        wr      = 1'b1;
        rv      = 1'b0;
        dati    = 8'h00;
        m_joy   = '0;
        m_axes  = {2{20'h80200}};
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        check("reset_dato", dato, 8'h00);

        push_frame(0, 8'h10, 8'h00, 8'hFF, 8'h03, 8'h03, 11'h0AA, 20'hFFC10);
        push_frame(1, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 11'h000, 20'h80200);
        push_frame(0, 8'hB0, 8'h00, 8'h00, 8'h02, 8'h00, 11'h002, 20'h800B0);
        push_frame(1, 8'hFF, 8'h03, 8'h00, 8'h00, 8'h00, 11'h005, 20'h003FF);
        push_frame(0, 8'hD0, 8'h00, 8'h00, 8'h02, 8'h00, HYST_ON ? 11'h002 : 11'h000, 20'h800D0);
        push_frame(1, 8'h40, 8'h03, 8'h40, 8'h03, 8'h01, 11'h089, 20'hD0340);
        push_frame(0, 8'h10, 8'h01, 8'hC0, 8'h00, 8'h02, 11'h020, 20'h30110);
        push_frame(1, 8'h3F, 8'h03, 8'hBF, 8'h00, 8'h00, HYST_ON ? 11'h005 : 11'h004, 20'h2FF3F);
        push_frame(0, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 11'h000, 20'h80200);
        byte_q.push_back(8'h11);
        byte_q.push_back(8'h22);
        byte_q.push_back(8'h33);
        ch_exp.push_back(1);

        reset_n = 1'b1;
        wait_first_sel("initial");

        n = 0;
        while (served < 48 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check("bytes_before_reset", served, 48);
        repeat (10) @(negedge clk);
        check("frames_before_reset", sb.size(), 0);

        #2 reset_n = 1'b0;
        #1 check_reset_values("midframe");
        byte_q.delete();
        ch_exp.delete();
        sb.delete();
        m_joy  = '0;
        m_axes = {2{20'h80200}};
        repeat (3) @(negedge clk);
        check_reset_values("held_reset");

        push_frame(0, 8'h10, 8'h00, 8'hFF, 8'h03, 8'h03, 11'h0AA, 20'hFFC10);
        reset_n = 1'b1;
        wait_first_sel("post_reset");
        n = 0;
        while (sb.size() > 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("post_reset_drain", sb.size(), 0);
        repeat (20) @(negedge clk);
        check("sel_onehot", sel_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
